fib_stream_checker: RTL

Consumer-side companion for the 8-bit recurrence generators in the regression set. It drives the generator's 1-bit advance input and checks each returned byte against its own model of the pair recurrence (a,b) → (b, a+b mod 2^WIDTH). It acquires lock from two observed samples, then tracks, counting mismatches and re-acquiring after sustained loss. It sits in the regression harness facing the generator top level: its `advance` feeds the generator input, and the generator's byte output feeds `sample`.

---
 rtl/fib_stream_checker.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fib_stream_checker.sv
// fib_stream_checker
//
// Consumer-side checker for a pair-recurrence byte generator. The generator
// produces (a,b) -> (b, a+b mod 2^WIDTH). This block drives the generator's
// advance input, learns the generator state from two observed samples, and
// then compares every returned sample against its own copy of the
// recurrence. It counts mismatches and re-acquires after a run of
// consecutive misses.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          synchronous active-high reset
//   en           run enable; when low, advance=0 and all state holds
//   sample       generator output byte, valid every cycle
//   advance      advance request to the generator (combinational)
//   locked       high while the checker is tracking (registered)
//   mismatch     one-cycle pulse, the cycle after a failed compare
//   err_count    saturating count of mismatches since reset
//   first_bad    sample value of the first mismatch since reset
//   first_valid  first_bad holds a captured value
//
// Generator contract: in every cycle the generator presents a_t on sample.
// When advance is high in that cycle, the generator steps to
// (b_t, a_t+b_t) at the clock edge; otherwise it holds. There is no
// back-pressure: sample is always valid, and advance is the only control.

module fib_stream_checker #(
   parameter int WIDTH       = 8,
   parameter int ERR_W       = 8,
   parameter int HOLD_PERIOD = 3,
   parameter int LOSS        = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] sample,
   output logic             advance,
   output logic             locked,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] first_bad,
   output logic             first_valid
);

   localparam int HC_W = (HOLD_PERIOD > 0) ? $clog2(HOLD_PERIOD + 1) : 1;
   localparam int MC_W = (LOSS > 0) ? $clog2(LOSS + 1) : 1;
   localparam logic [HC_W-1:0]  HOLD_V  = HC_W'(HOLD_PERIOD);
   localparam logic [MC_W-1:0]  LOSS_V  = MC_W'(LOSS);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   typedef enum logic [1:0] {
      ACQ0  = 2'd0,
      ACQ1  = 2'd1,
      TRACK = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] x0;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [HC_W-1:0]  hc;
   logic [MC_W-1:0]  mc;

   logic             track_adv;
   logic             miss;
   logic             lost;
   logic [MC_W-1:0]  mc_inc;

   always_comb begin
      // In TRACK a hold cycle is inserted once hc has counted HOLD_PERIOD
      // advances; HOLD_PERIOD of zero disables holds entirely.
      track_adv = (HOLD_PERIOD == 0) || (hc != HOLD_V);
      miss      = (state == TRACK) && (sample != a);
      mc_inc    = mc + MC_W'(1);
      lost      = (LOSS != 0) && (mc_inc == LOSS_V);

      advance = 1'b0;
      if (!rst && en) begin
         advance = (state == TRACK) ? track_adv : 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ACQ0;
         x0          <= '0;
         a           <= '0;
         b           <= '0;
         hc          <= '0;
         mc          <= '0;
         locked      <= 1'b0;
         mismatch    <= 1'b0;
         err_count   <= '0;
         first_bad   <= '0;
         first_valid <= 1'b0;
      end else begin
         mismatch <= 1'b0;
         if (en) begin
            case (state)
               ACQ0: begin
                  x0     <= sample;
                  state  <= ACQ1;
                  locked <= 1'b0;
               end
               ACQ1: begin
                  // Samples x0, x1 were taken with advance high, so the
                  // generator is now at (x0+x1, x0+2*x1).
                  a      <= x0 + sample;
                  b      <= x0 + sample + sample;
                  hc     <= '0;
                  mc     <= '0;
                  state  <= TRACK;
                  locked <= 1'b1;
               end
               TRACK: begin
                  if (track_adv) begin
                     hc <= hc + HC_W'(1);
                     a  <= b;
                     b  <= a + b;
                  end else begin
                     hc <= '0;
                  end
                  if (miss) begin
                     mismatch <= 1'b1;
                     if (err_count != ERR_MAX) begin
                        err_count <= err_count + ERR_W'(1);
                     end
                     if (!first_valid) begin
                        first_bad   <= sample;
                        first_valid <= 1'b1;
                     end
                     if (lost) begin
                        // Model update above is discarded by re-acquire.
                        state  <= ACQ0;
                        locked <= 1'b0;
                        mc     <= '0;
                     end else begin
                        mc <= mc_inc;
                     end
                  end else begin
                     mc <= '0;
                  end
               end
               default: begin
                  state  <= ACQ0;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
